// File: rtl/reg_exec_ctrl.sv
// rtl/reg_exec_ctrl.sv - multi-cycle execute/control stage driving a 4x8-bit register group
module reg_exec_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic [7:0] imm,
    output logic [1:0] sr,
    output logic [1:0] dr,
    input  logic [7:0] s,
    input  logic [7:0] d,
    output logic       we,
    output logic [7:0] i,
    output logic [7:0] result,
    output logic       flag_c,
    output logic       flag_z,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] opcode_q;
    logic [7:0] imm_q;
    logic [1:0] sr_q;
    logic [1:0] dr_q;
    logic [7:0] op_a_q;
    logic [7:0] op_b_q;
    logic       we_q;
    logic [7:0] i_q;
    logic [7:0] result_q;
    logic       c_q;
    logic       z_q;
    logic       busy_q;
    logic       done_q;

    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [8:0] inc9;
    logic [7:0] alu_res_d;
    logic       alu_c_d;
    logic       alu_z_d;
    logic       alu_wr_d;

    // ALU: op_a is the source operand, op_b the destination operand; NOPs keep result and carry
    always_comb begin
        sum9      = {1'b0, op_b_q} + {1'b0, op_a_q};
        diff9     = {1'b0, op_b_q} - {1'b0, op_a_q};
        inc9      = {1'b0, op_b_q} + 9'd1;
        alu_res_d = result_q;
        alu_c_d   = c_q;
        alu_wr_d  = 1'b1;
        case (opcode_q)
            4'h0: alu_res_d = op_a_q;
            4'h1: {alu_c_d, alu_res_d} = sum9;
            4'h2: {alu_c_d, alu_res_d} = diff9;
            4'h3: alu_res_d = op_b_q & op_a_q;
            4'h4: alu_res_d = op_b_q | op_a_q;
            4'h5: alu_res_d = op_b_q ^ op_a_q;
            4'h6: alu_res_d = ~op_a_q;
            4'h7: {alu_c_d, alu_res_d} = inc9;
            4'h8: alu_res_d = imm_q;
            4'h9: begin
                alu_res_d = {op_a_q[6:0], 1'b0};
                alu_c_d   = op_a_q[7];
            end
            4'hA: begin
                alu_res_d = {1'b0, op_a_q[7:1]};
                alu_c_d   = op_a_q[0];
            end
            default: alu_wr_d = 1'b0;
        endcase
        alu_z_d = (alu_res_d == 8'h00);
    end

    // Control FSM with registered outputs; async reset kills any pending write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opcode_q <= 4'h0;
            imm_q    <= 8'h00;
            sr_q     <= 2'd0;
            dr_q     <= 2'd0;
            op_a_q   <= 8'h00;
            op_b_q   <= 8'h00;
            we_q     <= 1'b0;
            i_q      <= 8'h00;
            result_q <= 8'h00;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opcode_q <= instr[7:4];
                        imm_q    <= imm;
                        sr_q     <= instr[3:2];
                        dr_q     <= instr[1:0];
                        busy_q   <= 1'b1;
                        state_q  <= ST_READ;
                    end
                end
                ST_READ: begin
                    op_a_q  <= s;
                    op_b_q  <= d;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (alu_wr_d) begin
                        i_q      <= alu_res_d;
                        result_q <= alu_res_d;
                        c_q      <= alu_c_d;
                        z_q      <= alu_z_d;
                        we_q     <= 1'b1;
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign sr          = sr_q;
    assign dr          = dr_q;
    assign we          = we_q;
    assign i           = i_q;
    assign result      = result_q;
    assign flag_c      = c_q;
    assign flag_z      = z_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_reg_exec_ctrl.sv
// tb/tb_reg_exec_ctrl.sv - directed self-checking bench for reg_exec_ctrl with a register group model
module tb_reg_exec_ctrl;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [1:0] sr;
    logic [1:0] dr;
    logic [7:0] s;
    logic [7:0] d;
    logic       we;
    logic [7:0] i;
    logic [7:0] result;
    logic       flag_c;
    logic       flag_z;
    logic       busy;
    logic       done;

    int total;
    int bad;

    logic [7:0] regs [4];
    logic       pl_we;
    logic [1:0] pl_sel;
    logic [7:0] pl_val;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    reg_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .sr          (sr),
        .dr          (dr),
        .s           (s),
        .d           (d),
        .we          (we),
        .i           (i),
        .result      (result),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register group model: combinational reads, negedge write
    assign s = regs[sr];
    assign d = regs[dr];
    always @(negedge clk) begin
        if (we) regs[dr] <= i;
        else if (pl_we) regs[pl_sel] <= pl_val;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] sel, input logic [7:0] val);
        pl_sel = sel;
        pl_val = val;
        pl_we  = 1'b1;
        @(negedge clk);
        #1;
        pl_we  = 1'b0;
    endtask

    // present one instruction, return at accept edge T0 + 1
    task automatic issue(input logic [7:0] ins, input logic [7:0] im);
        int k;
        k = 0;
        while (!instr_ready && k < 20) begin
            step();
            k++;
        end
        total++;
        if (!instr_ready) begin
            bad++;
            $display("FAIL issue_timeout: instr_ready=%b required 1", instr_ready);
        end
        instr       = ins;
        imm         = im;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({instr_ready, busy, done, we, flag_c, flag_z} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: rdy/busy/done/we/c/z=%b required 000000",
                     {instr_ready, busy, done, we, flag_c, flag_z});
        end
        total++;
        if ({sr, dr, i, result} !== 20'h0) begin
            bad++;
            $display("FAIL reset_data: sr=%0d dr=%0d i=%h result=%h required 0 0 00 00", sr, dr, i, result);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: %b required 1", instr_ready);
        end
    endtask

    task automatic test_add();
        preload(2'd0, 8'h01);
        preload(2'd3, 8'h07);
        issue(8'h13, 8'h00);
        total++;
        if ({busy, instr_ready, done, we, sr, dr} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3}) begin
            bad++;
            $display("FAIL add_read: busy/rdy/done/we=%b sr=%0d dr=%0d required 1000 0 3",
                     {busy, instr_ready, done, we}, sr, dr);
        end
        step();
        total++;
        if ({done, we} !== 2'b00) begin
            bad++;
            $display("FAIL add_exec: done/we=%b required 00", {done, we});
        end
        step();
        total++;
        if ({done, we, i, sr, dr} !== {1'b1, 1'b1, 8'h08, 2'd0, 2'd3}) begin
            bad++;
            $display("FAIL add_wb: done=%b we=%b i=%h sr=%0d dr=%0d required 1 1 08 0 3", done, we, i, sr, dr);
        end
        step();
        total++;
        if ({done, we, busy, instr_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL add_end: done/we/busy/rdy=%b required 0001", {done, we, busy, instr_ready});
        end
        total++;
        if ({regs[3], result, flag_c, flag_z} !== {8'h08, 8'h08, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL add_result: R3=%h result=%h C=%b Z=%b required 08 08 0 0", regs[3], result, flag_c, flag_z);
        end
    endtask

    task automatic test_overflow();
        preload(2'd1, 8'hFF);
        preload(2'd2, 8'h01);
        issue(8'h19, 8'h00);
        step();
        step();
        total++;
        if ({we, i} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL ovf_wb: we=%b i=%h required 1 00", we, i);
        end
        step();
        total++;
        if ({regs[1], flag_c, flag_z} !== {8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ovf_result: R1=%h C=%b Z=%b required 00 1 1", regs[1], flag_c, flag_z);
        end
    endtask

    task automatic test_sub_nop();
        int we_seen;
        int done_cnt;
        preload(2'd0, 8'h01);
        preload(2'd2, 8'h00);
        issue(8'h22, 8'h00);
        step();
        step();
        total++;
        if ({we, i} !== {1'b1, 8'hFF}) begin
            bad++;
            $display("FAIL sub_wb: we=%b i=%h required 1 ff", we, i);
        end
        step();
        total++;
        if ({regs[2], flag_c, flag_z} !== {8'hFF, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_result: R2=%h C=%b Z=%b required ff 1 0", regs[2], flag_c, flag_z);
        end
        we_seen  = 0;
        done_cnt = 0;
        issue(8'hF0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            if (we) we_seen++;
            if (done) done_cnt++;
            step();
        end
        total++;
        if (we_seen != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL nop_pulses: we_cycles=%0d done_cycles=%0d required 0 1", we_seen, done_cnt);
        end
        total++;
        if ({result, flag_c, flag_z, regs[0]} !== {8'hFF, 1'b1, 1'b0, 8'h01}) begin
            bad++;
            $display("FAIL nop_state: result=%h C=%b Z=%b R0=%h required ff 1 0 01", result, flag_c, flag_z, regs[0]);
        end
    endtask

    task automatic test_back_to_back();
        int low_cnt;
        low_cnt     = 0;
        instr       = 8'h81;
        imm         = 8'h80;
        instr_valid = 1'b1;
        step();
        instr = 8'h95;
        imm   = 8'h00;
        for (int k = 0; k < 3; k++) begin
            if (!instr_ready) low_cnt++;
            step();
        end
        total++;
        if (low_cnt != 3 || instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: low_cycles=%0d ready_at_T3=%b required 3 1", low_cnt, instr_ready);
        end
        total++;
        if (regs[1] !== 8'h80) begin
            bad++;
            $display("FAIL b2b_ldi: R1=%h required 80", regs[1]);
        end
        step();
        instr_valid = 1'b0;
        total++;
        if ({busy, instr_ready, sr, dr} !== {1'b1, 1'b0, 2'd1, 2'd1}) begin
            bad++;
            $display("FAIL b2b_accept_T4: busy=%b rdy=%b sr=%0d dr=%0d required 1 0 1 1", busy, instr_ready, sr, dr);
        end
        step();
        step();
        step();
        total++;
        if ({regs[1], flag_c, flag_z, instr_ready} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL b2b_final: R1=%h C=%b Z=%b rdy=%b required 00 1 1 1", regs[1], flag_c, flag_z, instr_ready);
        end
    endtask

    task automatic test_alias();
        preload(2'd2, 8'h21);
        issue(8'h1A, 8'h00);
        step();
        step();
        step();
        total++;
        if ({regs[2], flag_c, flag_z} !== {8'h42, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL alias_add: R2=%h C=%b Z=%b required 42 0 0", regs[2], flag_c, flag_z);
        end
    endtask

    task automatic test_opcodes();
        vec_t tbl [9];
        logic [7:0] wb_i;
        logic       wb_we;
        tbl[0] = '{op: 4'h1, a: 8'h80, b: 8'h80, res: 8'h00, c: 1'b1, z: 1'b1};
        tbl[1] = '{op: 4'h3, a: 8'hF0, b: 8'h3C, res: 8'h30, c: 1'b1, z: 1'b0};
        tbl[2] = '{op: 4'h4, a: 8'h0F, b: 8'h30, res: 8'h3F, c: 1'b1, z: 1'b0};
        tbl[3] = '{op: 4'h5, a: 8'hFF, b: 8'hFF, res: 8'h00, c: 1'b1, z: 1'b1};
        tbl[4] = '{op: 4'hA, a: 8'h02, b: 8'h77, res: 8'h01, c: 1'b0, z: 1'b0};
        tbl[5] = '{op: 4'h0, a: 8'h00, b: 8'h55, res: 8'h00, c: 1'b0, z: 1'b1};
        tbl[6] = '{op: 4'h6, a: 8'h5A, b: 8'h00, res: 8'hA5, c: 1'b0, z: 1'b0};
        tbl[7] = '{op: 4'h7, a: 8'h12, b: 8'hFF, res: 8'h00, c: 1'b1, z: 1'b1};
        tbl[8] = '{op: 4'h2, a: 8'h20, b: 8'h50, res: 8'h30, c: 1'b0, z: 1'b0};
        for (int n = 0; n < 9; n++) begin
            preload(2'd0, tbl[n].a);
            preload(2'd1, tbl[n].b);
            issue({tbl[n].op, 4'b0001}, 8'h00);
            step();
            step();
            wb_i  = i;
            wb_we = we;
            step();
            total++;
            if ({wb_we, wb_i, regs[1], flag_c, flag_z} !== {1'b1, tbl[n].res, tbl[n].res, tbl[n].c, tbl[n].z}) begin
                bad++;
                $display("FAIL op_%0h: we=%b i=%h R1=%h C=%b Z=%b required 1 %h %h %b %b",
                         tbl[n].op, wb_we, wb_i, regs[1], flag_c, flag_z,
                         tbl[n].res, tbl[n].res, tbl[n].c, tbl[n].z);
            end
        end
    endtask

    task automatic test_reset_midop();
        int we_seen;
        we_seen = 0;
        preload(2'd0, 8'h01);
        preload(2'd3, 8'h07);
        issue(8'h13, 8'h00);
        step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({we, busy, done, instr_ready, flag_c, flag_z, sr, dr, i, result} !== 26'h0) begin
            bad++;
            $display("FAIL midop_reset_vals: we=%b busy=%b done=%b rdy=%b C=%b Z=%b sr=%0d dr=%0d i=%h result=%h required all 0",
                     we, busy, done, instr_ready, flag_c, flag_z, sr, dr, i, result);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (we || done) we_seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (we_seen != 0 || regs[3] !== 8'h07) begin
            bad++;
            $display("FAIL midop_no_write: we_or_done_cycles=%0d R3=%h required 0 07", we_seen, regs[3]);
        end
        total++;
        if (instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL midop_release_ready: %b required 1", instr_ready);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 8'h00;
        imm         = 8'h00;
        pl_we       = 1'b0;
        pl_sel      = 2'd0;
        pl_val      = 8'h00;
        test_reset();
        test_add();
        test_overflow();
        test_sub_nop();
        test_back_to_back();
        test_alias();
        test_opcodes();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_exec_ctrl.md
# reg_exec_ctrl

Multi-cycle execute/control stage that sits directly upstream of the 4×8-bit register group. It accepts one 8-bit instruction (plus optional immediate) per handshake and drives the register group's `sr`/`dr` select lines. It reads the two operands back from the group's combinational `s`/`d` outputs, computes an ALU result with carry/zero flags, and writes the result back through `we`/`i`. Write-back timing is aligned to the register group's negedge write.

## Interface
- No parameters; all datapaths are fixed at 8 bits with 2-bit register selects.
- `clk` in 1: single clock. All state updates happen on the posedge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: the instruction source has `instr`/`imm` valid.
- `instr_ready` out 1: block can accept. Equals 1 only in IDLE with `rst`=0.
- `instr` in 8: `[7:4]` opcode, `[3:2]` source select, `[1:0]` destination select.
- `imm` in 8: immediate for LDI. Latched with `instr`.
- `sr` out 2: source register select to the register group.
- `dr` out 2: destination register select to the register group.
- `s` in 8: source operand from the register group (combinational).
- `d` in 8: destination operand from the register group (combinational).
- `we` out 1: write enable to the register group.
- `i` out 8: write data to the register group.
- `result` out 8: last computed result, held.
- `flag_c` out 1: carry/borrow flag.
- `flag_z` out 1: zero flag.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse, high during WB.

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE. There are no other states. Unused encodings return to IDLE.
- **IDLE**
  - On posedge with `instr_valid && instr_ready`, latch `instr` and `imm`.
  - Drive `sr`=`instr[3:2]` and `dr`=`instr[1:0]` (registered).
  - Go to READ.
- **READ**
  - `sr`/`dr` are stable, so `s`/`d` settle.
  - At the closing posedge, capture `s`→`op_a` and `d`→`op_b`. Go to EXEC.
- **EXEC**
  - Compute from `op_a` (s) and `op_b` (d) according to the opcode.
  - At the closing posedge, register `i`, `result`, and the flags. Go to WB.
- **WB**
  - `we`=1 for writing opcodes, 0 otherwise. `done`=1.
  - `sr`/`dr`/`i` are held stable for the whole cycle.
  - Go to IDLE.
- **Opcodes** (result is 8-bit; the carry is bit 8 of the 9-bit sum):
  - 0 MOV: s. C unchanged.
  - 1 ADD: d+s. C = carry-out.
  - 2 SUB: d−s. C = borrow (d<s unsigned).
  - 3 AND: d&s. C unchanged.
  - 4 OR: d|s. C unchanged.
  - 5 XOR: d^s. C unchanged.
  - 6 NOT: ~s. C unchanged.
  - 7 INC: d+1. C = carry-out.
  - 8 LDI: imm. C unchanged.
  - 9 SHL: s<<1. C = s[7].
  - A SHR: s>>1 (logical). C = s[0].
  - B–F NOP: no write; `result`, C and Z are unchanged.
- **Z flag:** Z=(result==0) for every writing opcode. NOP leaves Z unchanged.
- **Register aliasing:** sr==dr is legal. Both operands are the same register; for example, ADD R1,R1 doubles R1.
- **`instr_valid` outside IDLE:** ignored. The instruction is not consumed because `instr_ready`=0.

## Timing
- **Reset values** (asynchronous, taking effect immediately on `rst` rising):
  - FSM = IDLE.
  - `sr`=0, `dr`=0.
  - `we`=0, `i`=0x00.
  - `result`=0x00, `flag_c`=0, `flag_z`=0.
  - `done`=0, `busy`=0.
  - `instr_ready`=0 while `rst`=1; it becomes 1 in the first cycle after release.
- **Latency:** if the accept edge is T0, then READ is T0–T1, EXEC is T1–T2, WB is T2–T3.
- **Write landing:** the register group writes on the negedge inside WB. `we` rises at T2 and falls at T3.
- **Throughput:** one instruction per 4 cycles. `instr_ready` returns to 1 at T3, so back-to-back accepts land at T0, T4, T8, …
- **Read-after-write:** a dependent instruction sees the new value, because its READ starts at T4, after the negedge write in T2–T3.
- **Reset mid-operation:** `we` drops asynchronously, so no write occurs after `rst` rises. Register-group contents are untouched. The in-flight instruction is lost with no `done`.
- **Arithmetic:** wrap-around is modulo 256 with no saturation.

## Test plan
- **ADD:** reset, then preload the group to R0=0x01, R3=0x07.
  - Stimulus: accept ADD sr=0, dr=3 (`instr`=0x13).
  - Required: `we`=1 during WB with `i`=0x08. R3=0x08 afterwards. C=0, Z=0. `done` is a single one-cycle pulse at T2.
- **Overflow:** R1=0xFF, R2=0x01; accept ADD sr=2, dr=1 (`instr`=0x19).
  - Required: `i`=0x00, C=1, Z=1.
- **SUB borrow, then NOP:** R0=0x01, R2=0x00; accept SUB sr=0, dr=2 (`instr`=0x22).
  - Required: `i`=0xFF, C=1, Z=0.
  - Follow with NOP (`instr`=0xF0). Required: `we` stays 0, flags stay C=1/Z=0, `done` pulses.
- **Back-to-back with dependency:** hold `instr_valid`=1 for LDI dr=1, imm=0x80, then SHL sr=1, dr=1.
  - Required: accepts at T0 and T4, `instr_ready` low for 3 cycles each.
  - Final state: R1=0x00, C=1, Z=1.
- **Reset mid-op:** assert `rst` during EXEC of an ADD.
  - Required: `we` never rises, the destination register is unchanged, and all outputs take their reset values immediately.
  - After release: `instr_ready`=1 in the next cycle.
